// File: rtl/dcache_nb_ctrl.sv
// Non-blocking write-through data-cache controller with NUM_MSHR outstanding line fills.
// Fills take priority over processor requests; secondary load misses merge onto pending fills.
module dcache_nb_ctrl #(
  parameter int unsigned NUM_MSHR     = 4,
  parameter int unsigned MEM_TAG_BITS = 4,
  parameter int unsigned IDX_BITS     = 5,
  parameter int unsigned TAG_BITS     = 8
) (
  input  logic                            clock,
  input  logic                            reset,

  input  logic [1:0]                      proc2Dcache_command,
  input  logic [63:0]                     proc2Dcache_addr,
  input  logic [63:0]                     proc2Dcache_data,
  output logic [63:0]                     Dcache2proc_data,
  output logic                            Dcache2proc_valid,
  output logic [MEM_TAG_BITS-1:0]         Dcache2proc_tag,
  output logic                            Dcache2proc_st_received,
  output logic                            Dcache2proc_reject,

  input  logic [MEM_TAG_BITS-1:0]         Dmem2Dcache_response,
  input  logic [MEM_TAG_BITS-1:0]         Dmem2Dcache_tag,
  input  logic [63:0]                     Dmem2Dcache_data,
  output logic [1:0]                      Dcache2Dmem_command,
  output logic [63:0]                     Dcache2Dmem_addr,
  output logic [63:0]                     Dcache2Dmem_data,

  input  logic [63:0]                     cachemem_data,
  input  logic                            cachemem_valid,
  output logic [IDX_BITS-1:0]             rd_idx,
  output logic [TAG_BITS-1:0]             rd_tag,
  output logic [IDX_BITS-1:0]             wr_idx,
  output logic [TAG_BITS-1:0]             wr_tag,
  output logic [63:0]                     wr_data,
  output logic                            wr_en,
  output logic                            en,

  output logic [$clog2(NUM_MSHR+1)-1:0]   mshr_count
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam int unsigned CntW = $clog2(NUM_MSHR + 1);
  localparam int unsigned IdxW = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;

  // MSHR storage
  logic [NUM_MSHR-1:0]     valid_q, valid_d;
  logic [NUM_MSHR-1:0]     nofill_q, nofill_d;
  logic [60:0]             line_q [NUM_MSHR];
  logic [60:0]             line_d [NUM_MSHR];
  logic [MEM_TAG_BITS-1:0] mtag_q [NUM_MSHR];
  logic [MEM_TAG_BITS-1:0] mtag_d [NUM_MSHR];
  logic [CntW-1:0]         count_q, count_d;

  logic [60:0]   proc_line;
  logic [60:0]   fill_line;
  logic          fill_hit, line_hit, free_any;
  logic [IdxW-1:0] fill_idx, line_idx, free_idx;
  logic          alloc, release_entry;
  logic          unused_addr_lsb;

  assign proc_line       = proc2Dcache_addr[63:3];
  assign unused_addr_lsb = ^proc2Dcache_addr[2:0];
  assign fill_line       = line_q[fill_idx];
  assign mshr_count      = count_q;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    fill_hit = 1'b0;
    fill_idx = '0;
    line_hit = 1'b0;
    line_idx = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (valid_q[i] && (Dmem2Dcache_tag != '0) && (mtag_q[i] == Dmem2Dcache_tag)) begin
        fill_hit = 1'b1;
        fill_idx = IdxW'(i);
      end
      if (valid_q[i] && (line_q[i] == proc_line)) begin
        line_hit = 1'b1;
        line_idx = IdxW'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IdxW'(i);
      end
    end
  end

  always_comb begin
    Dcache2proc_data        = '0;
    Dcache2proc_valid       = 1'b0;
    Dcache2proc_tag         = '0;
    Dcache2proc_st_received = 1'b0;
    Dcache2proc_reject      = 1'b0;
    Dcache2Dmem_command     = BUS_NONE;
    Dcache2Dmem_addr        = '0;
    Dcache2Dmem_data        = '0;
    rd_idx                  = '0;
    rd_tag                  = '0;
    wr_idx                  = '0;
    wr_tag                  = '0;
    wr_data                 = '0;
    wr_en                   = 1'b0;
    en                      = 1'b0;
    alloc                   = 1'b0;
    release_entry           = 1'b0;
    valid_d                 = valid_q;
    nofill_d                = nofill_q;
    line_d                  = line_q;
    mtag_d                  = mtag_q;

    if (!reset) begin
      if (fill_hit) begin
        Dcache2proc_data   = Dmem2Dcache_data;
        Dcache2proc_valid  = 1'b1;
        Dcache2proc_tag    = Dmem2Dcache_tag;
        Dcache2proc_reject = (proc2Dcache_command != BUS_NONE);
        wr_en              = !nofill_q[fill_idx];
        en                 = !nofill_q[fill_idx];
        wr_idx             = fill_line[IDX_BITS-1:0];
        wr_tag             = fill_line[IDX_BITS+TAG_BITS-1:IDX_BITS];
        wr_data            = Dmem2Dcache_data;
        release_entry      = 1'b1;
        valid_d[fill_idx]  = 1'b0;
        nofill_d[fill_idx] = 1'b0;
      end else if (proc2Dcache_command == BUS_LOAD) begin
        rd_idx = proc2Dcache_addr[IDX_BITS+2:3];
        rd_tag = proc2Dcache_addr[IDX_BITS+TAG_BITS+2:IDX_BITS+3];
        en     = 1'b1;
        if (cachemem_valid) begin
          Dcache2proc_data  = cachemem_data;
          Dcache2proc_valid = 1'b1;
        end else if (line_hit) begin
          Dcache2proc_tag = mtag_q[line_idx];
        end else if (free_any && (Dmem2Dcache_response != '0)) begin
          Dcache2Dmem_command = BUS_LOAD;
          Dcache2Dmem_addr    = {proc_line, 3'b000};
          Dcache2proc_tag     = Dmem2Dcache_response;
          alloc               = 1'b1;
          valid_d[free_idx]   = 1'b1;
          nofill_d[free_idx]  = 1'b0;
          line_d[free_idx]    = proc_line;
          mtag_d[free_idx]    = Dmem2Dcache_response;
        end else begin
          Dcache2proc_reject = 1'b1;
        end
      end else if (proc2Dcache_command == BUS_STORE) begin
        if (Dmem2Dcache_response == '0) begin
          Dcache2proc_reject = 1'b1;
        end else begin
          Dcache2Dmem_command     = BUS_STORE;
          Dcache2Dmem_addr        = {proc_line, 3'b000};
          Dcache2Dmem_data        = proc2Dcache_data;
          Dcache2proc_st_received = 1'b1;
          Dcache2proc_tag         = Dmem2Dcache_response;
          wr_en                   = 1'b1;
          en                      = 1'b1;
          wr_idx                  = proc2Dcache_addr[IDX_BITS+2:3];
          wr_tag                  = proc2Dcache_addr[IDX_BITS+TAG_BITS+2:IDX_BITS+3];
          wr_data                 = proc2Dcache_data;
          // The pending fill would overwrite the newer store data in the array.
          if (line_hit) nofill_d[line_idx] = 1'b1;
        end
      end
    end

    count_d = count_q + CntW'(alloc) - CntW'(release_entry);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q  <= '0;
      nofill_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      nofill_q <= nofill_d;
      count_q  <= count_d;
      line_q   <= line_d;
      mtag_q   <= mtag_d;
    end
  end

endmodule

// File: tb/tb_dcache_nb_ctrl.sv
// Directed and randomized bench for dcache_nb_ctrl against a tag-keyed MSHR model.
module tb_dcache_nb_ctrl;

  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  proc2Dcache_command;
  logic [63:0] proc2Dcache_addr, proc2Dcache_data;
  logic [63:0] Dcache2proc_data;
  logic        Dcache2proc_valid;
  logic [3:0]  Dcache2proc_tag;
  logic        Dcache2proc_st_received, Dcache2proc_reject;
  logic [3:0]  Dmem2Dcache_response, Dmem2Dcache_tag;
  logic [63:0] Dmem2Dcache_data;
  logic [1:0]  Dcache2Dmem_command;
  logic [63:0] Dcache2Dmem_addr, Dcache2Dmem_data;
  logic [63:0] cachemem_data;
  logic        cachemem_valid;
  logic [4:0]  rd_idx, wr_idx;
  logic [7:0]  rd_tag, wr_tag;
  logic [63:0] wr_data;
  logic        wr_en, en;
  logic [2:0]  mshr_count;

  dcache_nb_ctrl dut (
    .clock                   (clock),
    .reset                   (reset),
    .proc2Dcache_command     (proc2Dcache_command),
    .proc2Dcache_addr        (proc2Dcache_addr),
    .proc2Dcache_data        (proc2Dcache_data),
    .Dcache2proc_data        (Dcache2proc_data),
    .Dcache2proc_valid       (Dcache2proc_valid),
    .Dcache2proc_tag         (Dcache2proc_tag),
    .Dcache2proc_st_received (Dcache2proc_st_received),
    .Dcache2proc_reject      (Dcache2proc_reject),
    .Dmem2Dcache_response    (Dmem2Dcache_response),
    .Dmem2Dcache_tag         (Dmem2Dcache_tag),
    .Dmem2Dcache_data        (Dmem2Dcache_data),
    .Dcache2Dmem_command     (Dcache2Dmem_command),
    .Dcache2Dmem_addr        (Dcache2Dmem_addr),
    .Dcache2Dmem_data        (Dcache2Dmem_data),
    .cachemem_data           (cachemem_data),
    .cachemem_valid          (cachemem_valid),
    .rd_idx                  (rd_idx),
    .rd_tag                  (rd_tag),
    .wr_idx                  (wr_idx),
    .wr_tag                  (wr_tag),
    .wr_data                 (wr_data),
    .wr_en                   (wr_en),
    .en                      (en),
    .mshr_count              (mshr_count)
  );

  always #5 clock = ~clock;

  // Reference: outstanding fills keyed by Dmem tag.
  typedef struct packed {
    logic [60:0] line;
    logic        nofill;
  } ent_t;
  ent_t model [int];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  // Drive one cycle at the negedge, check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input logic rst, input logic [1:0] cmd, input logic [63:0] addr,
                      input logic [63:0] data, input logic [3:0] resp, input logic [3:0] ftag,
                      input logic [63:0] fdata, input logic cv, input logic [63:0] cd);
    logic [60:0] line;
    logic        fill, alloc, st_ok, found, e_valid, e_st, e_rej, e_wr;
    logic [3:0]  e_tag;
    logic [1:0]  e_cmd;
    logic [63:0] e_data, e_wdata;
    logic [60:0] e_wline;
    int          mk;
    reset = rst; proc2Dcache_command = cmd; proc2Dcache_addr = addr; proc2Dcache_data = data;
    Dmem2Dcache_response = resp; Dmem2Dcache_tag = ftag; Dmem2Dcache_data = fdata;
    cachemem_valid = cv; cachemem_data = cd;
    line = addr[63:3];
    fill = !rst && ftag != 0 && model.exists(int'(ftag));
    found = 1'b0; mk = 0;
    foreach (model[k]) if (model[k].line == line) begin found = 1'b1; mk = k; end
    alloc = 0; st_ok = 0; e_valid = 0; e_st = 0; e_rej = 0; e_wr = 0;
    e_tag = 0; e_cmd = NONE; e_data = 0; e_wdata = 0; e_wline = 0;
    if (rst) begin
    end else if (fill) begin
      e_valid = 1; e_tag = ftag; e_data = fdata; e_rej = (cmd != NONE);
      e_wr = !model[int'(ftag)].nofill; e_wline = model[int'(ftag)].line; e_wdata = fdata;
    end else if (cmd == LOAD) begin
      if (cv) begin e_valid = 1; e_data = cd; end
      else if (found) e_tag = 4'(mk);
      else if (model.num() < 4 && resp != 0) begin alloc = 1; e_cmd = LOAD; e_tag = resp; end
      else e_rej = 1;
    end else if (cmd == STORE) begin
      if (resp == 0) e_rej = 1;
      else begin
        st_ok = 1; e_cmd = STORE; e_st = 1; e_tag = resp; e_wr = 1; e_wline = line; e_wdata = data;
      end
    end
    #2;
    chk("mshr_count", 64'(mshr_count), 64'(model.num()));
    chk("proc_valid", 64'(Dcache2proc_valid), 64'(e_valid));
    chk("proc_tag", 64'(Dcache2proc_tag), 64'(e_tag));
    chk("st_received", 64'(Dcache2proc_st_received), 64'(e_st));
    chk("reject", 64'(Dcache2proc_reject), 64'(e_rej));
    chk("dmem_cmd", 64'(Dcache2Dmem_command), 64'(e_cmd));
    chk("wr_en", 64'(wr_en), 64'(e_wr));
    if (e_valid) chk("proc_data", Dcache2proc_data, e_data);
    if (e_cmd != NONE) chk("dmem_addr", Dcache2Dmem_addr, {line, 3'b000});
    if (e_cmd == STORE) chk("dmem_data", Dcache2Dmem_data, data);
    if (e_wr) begin
      chk("wr_idx", 64'(wr_idx), 64'(e_wline[4:0]));
      chk("wr_tag", 64'(wr_tag), 64'(e_wline[12:5]));
      chk("wr_data", wr_data, e_wdata);
    end
    if (alloc) chk("dup_tag_alloc", 64'(model.exists(int'(resp))), 64'd0);
    @(posedge clock);
    if (rst) model.delete();
    else if (fill) model.delete(int'(ftag));
    else if (alloc) model[int'(resp)] = '{line: line, nofill: 1'b0};
    else if (st_ok && found) model[mk].nofill = 1'b1;
    @(negedge clock);
  endtask

  task automatic idle(input logic [3:0] ftag, input logic [63:0] fdata);
    step(0, NONE, 0, 0, 0, ftag, fdata, 0, 0);
  endtask

  initial begin
    int keys[$];
    logic [1:0]  cmd;
    logic [3:0]  resp, ftag;
    logic [63:0] addr;
    @(negedge clock);
    step(1, LOAD, 64'h40, 0, 4'd3, 4'd3, 0, 1, 64'h1);
    step(1, NONE, 0, 0, 0, 0, 0, 0, 0);
    // Hit
    step(0, LOAD, 64'h40, 0, 0, 0, 0, 1, 64'hDEAD);
    // Primary miss, secondary merge, fill
    step(0, LOAD, 64'h1000, 0, 4'd3, 0, 0, 0, 0);
    step(0, LOAD, 64'h1004, 0, 4'd0, 0, 0, 0, 0);
    chk("merge_count", 64'(mshr_count), 64'd1);
    idle(4'd3, 64'h55);
    chk("fill_freed", 64'(mshr_count), 64'd0);
    // Fill up all entries, overflow, retry after a fill
    for (int i = 0; i < 4; i++) step(0, LOAD, 64'h3000 + 64'(i * 8), 0, 4'(i + 1), 0, 0, 0, 0);
    chk("full_count", 64'(mshr_count), 64'd4);
    step(0, LOAD, 64'h3020, 0, 4'd5, 0, 0, 0, 0);
    step(0, LOAD, 64'h3020, 0, 4'd5, 4'd2, 64'h22, 0, 0);
    step(0, LOAD, 64'h3020, 0, 4'd5, 0, 0, 0, 0);
    idle(4'd1, 64'h11); idle(4'd3, 64'h33); idle(4'd4, 64'h44); idle(4'd5, 64'h5);
    // Store to a pending line suppresses its fill write
    step(0, LOAD, 64'h2000, 0, 4'd5, 0, 0, 0, 0);
    step(0, STORE, 64'h2000, 64'hBEEF, 4'd6, 0, 0, 0, 0);
    idle(4'd5, 64'h77);
    // Fill beats a concurrent load
    step(0, LOAD, 64'h4000, 0, 4'd1, 0, 0, 0, 0);
    step(0, LOAD, 64'h5000, 0, 4'd2, 4'd1, 64'h99, 0, 0);
    chk("fill_wins_count", 64'(mshr_count), 64'd0);
    // Store with busy Dmem
    step(0, STORE, 64'h6000, 64'h1234, 4'd0, 0, 0, 0, 0);
    // Reset with entries outstanding, then a stale fill tag
    for (int i = 0; i < 3; i++) step(0, LOAD, 64'h7000 + 64'(i * 8), 0, 4'(i + 7), 0, 0, 0, 0);
    chk("pre_reset_count", 64'(mshr_count), 64'd3);
    step(1, NONE, 0, 0, 0, 0, 0, 0, 0);
    step(0, LOAD, 64'h7000, 0, 4'd0, 4'd7, 64'hAA, 1, 64'hCAFE);
    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      keys.delete();
      foreach (model[k]) keys.push_back(k);
      cmd  = 2'($urandom_range(0, 2));
      addr = 64'h8000 + 64'($urandom_range(0, 11) * 8) + 64'($urandom_range(0, 7));
      resp = 0;
      if ($urandom_range(0, 4) != 0) begin
        do resp = 4'($urandom_range(1, 15)); while (model.exists(int'(resp)));
      end
      ftag = 0;
      if (keys.size() != 0 && $urandom_range(0, 2) == 0)
        ftag = 4'(keys[$urandom_range(0, keys.size() - 1)]);
      else if ($urandom_range(0, 7) == 0)
        ftag = 4'($urandom_range(1, 15));
      step($urandom_range(0, 49) == 0, cmd, addr, 64'({$urandom, $urandom}), resp, ftag,
           64'({$urandom, $urandom}), $urandom_range(0, 3) == 0, 64'({$urandom, $urandom}));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
